// File: rtl/demux4_feeder_if.sv
// Sample handshake and demux drive bundle for demux4_feeder.
// Master is the upstream producer/observer; slave is the feeder itself.
interface demux4_feeder_if #(
    parameter int DEPTH = 4
);
    logic                     s_valid;
    logic                     s_ready;
    logic [1:0]               s_chan;
    logic                     s_data;
    logic [1:0]               dmx_sel;
    logic                     dmx_data;
    logic                     dmx_active;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        output s_valid, s_chan, s_data,
        input  s_ready, dmx_sel, dmx_data, dmx_active, level
    );

    modport slave (
        input  s_valid, s_chan, s_data,
        output s_ready, dmx_sel, dmx_data, dmx_active, level
    );
endinterface

// File: rtl/demux4_feeder.sv
// Buffers (channel, bit) samples in a small FIFO and replays each one onto the
// demux sel/in0 inputs for HOLD_CYCLES cycles, back-to-back while samples wait.
module demux4_feeder #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int CW          = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    demux4_feeder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_r;
    logic [2:0]       mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic [CW-1:0]    cnt_r;
    logic [1:0]       sel_r;
    logic             data_r;
    logic             active_r;

    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic [2:0]       head_s;

    // Handshake qualification and pop decision (a pop only ever coincides with a load)
    always_comb begin
        full_s = (level_r == LW'(DEPTH));
        push_s = bus.s_valid && !full_s;
        head_s = mem_r[rd_ptr_r];
        pop_s  = 1'b0;
        case (state_r)
            IDLE:    pop_s = (level_r != {LW{1'b0}});
            HOLD:    pop_s = (level_r != {LW{1'b0}}) && (cnt_r == {CW{1'b0}});
            default: pop_s = 1'b0;
        endcase
    end

    // FIFO storage, pointers and occupancy; flush drops everything including a same-edge push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 3'b000;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {bus.s_chan, bus.s_data};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Presentation FSM: loads a sample, holds it, chains the next one without a gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= {CW{1'b0}};
            sel_r    <= 2'b00;
            data_r   <= 1'b0;
            active_r <= 1'b0;
        end else if (flush) begin
            // sel is deliberately held so the demux routing does not glitch
            state_r  <= IDLE;
            cnt_r    <= {CW{1'b0}};
            data_r   <= 1'b0;
            active_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        sel_r    <= head_s[2:1];
                        data_r   <= head_s[0];
                        active_r <= 1'b1;
                        cnt_r    <= CW'(HOLD_CYCLES - 1);
                        state_r  <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_r != {CW{1'b0}}) begin
                        cnt_r <= cnt_r - CW'(1);
                    end else if (pop_s) begin
                        sel_r    <= head_s[2:1];
                        data_r   <= head_s[0];
                        active_r <= 1'b1;
                        cnt_r    <= CW'(HOLD_CYCLES - 1);
                    end else begin
                        data_r   <= 1'b0;
                        active_r <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    cnt_r    <= {CW{1'b0}};
                    data_r   <= 1'b0;
                    active_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready    = !full_s;
    assign bus.level      = level_r;
    assign bus.dmx_sel    = sel_r;
    assign bus.dmx_data   = data_r;
    assign bus.dmx_active = active_r;

endmodule

// File: tb/tb_demux4_feeder.sv
// Scoreboard bench for demux4_feeder: directed stimulus queues expected samples,
// a monitor checks order, hold length and idle levels on the demux drive.
module tb_demux4_feeder;
    localparam int HOLD_A = 2;
    localparam int HOLD_B = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic flush_a;
    logic flush_b;

    demux4_feeder_if #(.DEPTH(4)) ifa ();
    demux4_feeder_if #(.DEPTH(4)) ifb ();

    demux4_feeder #(.DEPTH(4), .HOLD_CYCLES(HOLD_A), .CW(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush_a), .bus(ifa.slave)
    );
    demux4_feeder #(.DEPTH(4), .HOLD_CYCLES(HOLD_B), .CW(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(ifb.slave)
    );

    always #5 clk = ~clk;

    int         checks    = 0;
    int         failures  = 0;
    logic [2:0] exp_q[$];
    bit         mon_en    = 1'b0;
    int         hold_left = 0;
    logic [2:0] cur       = 3'b000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each presentation must match the queue head and last exactly HOLD_A cycles
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!mon_en) begin
                hold_left = 0;
            end else if (flush_a) begin
                exp_q.delete();
                hold_left = 0;
                chk("mon_flush_active", 32'(ifa.dmx_active), 32'd0);
                chk("mon_flush_data", 32'(ifa.dmx_data), 32'd0);
            end else if (ifa.dmx_active) begin
                if (hold_left == 0) begin
                    if (exp_q.size() == 0) begin
                        chk("mon_unexpected_sample", 32'(exp_q.size()), 32'd1);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("mon_sel", 32'(ifa.dmx_sel), 32'(cur[2:1]));
                        chk("mon_data", 32'(ifa.dmx_data), 32'(cur[0]));
                        hold_left = HOLD_A - 1;
                    end
                end else begin
                    chk("mon_hold_sel", 32'(ifa.dmx_sel), 32'(cur[2:1]));
                    chk("mon_hold_data", 32'(ifa.dmx_data), 32'(cur[0]));
                    hold_left--;
                end
            end else begin
                chk("mon_idle_data", 32'(ifa.dmx_data), 32'd0);
                if (hold_left != 0) begin
                    chk("mon_hold_cut_short", 32'(hold_left), 32'd0);
                    hold_left = 0;
                end
            end
        end
    end

    task automatic push_a(input logic [1:0] ch, input logic d);
        ifa.s_valid = 1'b1;
        ifa.s_chan  = ch;
        ifa.s_data  = d;
        exp_q.push_back({ch, d});
        @(negedge clk);
        ifa.s_valid = 1'b0;
    endtask

    task automatic wait_idle_a(input string name);
        int n = 0;
        while ((ifa.dmx_active || ifa.level != 3'd0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(ifa.dmx_active), 32'd0);
        chk({name, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [1:0] ch3 [4];
        logic [1:0] ch5 [4];
        logic       d5  [4];
        logic [2:0] lv5 [4];
        logic [1:0] chf [5];
        logic       df  [5];
        logic [2:0] lvf [5];
        logic [2:0] lvb [6];
        int         t;
        int         first;
        int         last;
        int         cnt_act;
        int         n;

        ch3 = '{2'd0, 2'd1, 2'd2, 2'd3};
        ch5 = '{2'd3, 2'd0, 2'd3, 2'd1};
        d5  = '{1'b0, 1'b1, 1'b1, 1'b0};
        lv5 = '{3'd1, 3'd1, 3'd2, 3'd2};
        chf = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        df  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        lvf = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3};
        lvb = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

        rst_n = 1'b0;
        flush_a = 1'b0;
        flush_b = 1'b0;
        ifa.s_valid = 1'b0; ifa.s_chan = 2'd0; ifa.s_data = 1'b0;
        ifb.s_valid = 1'b0; ifb.s_chan = 2'd0; ifb.s_data = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_active", 32'(ifa.dmx_active), 32'd0);
        chk("rst_data", 32'(ifa.dmx_data), 32'd0);
        chk("rst_sel", 32'(ifa.dmx_sel), 32'd0);
        chk("rst_level", 32'(ifa.level), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(ifa.s_ready), 32'd1);
        mon_en = 1'b1;
        @(negedge clk);

        // Single sample: visible one edge after the push, held two cycles
        push_a(2'd2, 1'b1);
        chk("single_level", 32'(ifa.level), 32'd1);
        chk("single_not_yet", 32'(ifa.dmx_active), 32'd0);
        @(negedge clk);
        chk("single_sel", 32'(ifa.dmx_sel), 32'd2);
        chk("single_data", 32'(ifa.dmx_data), 32'd1);
        chk("single_active1", 32'(ifa.dmx_active), 32'd1);
        @(negedge clk);
        chk("single_active2", 32'(ifa.dmx_active), 32'd1);
        @(negedge clk);
        chk("single_end_active", 32'(ifa.dmx_active), 32'd0);
        chk("single_end_data", 32'(ifa.dmx_data), 32'd0);
        chk("single_end_sel", 32'(ifa.dmx_sel), 32'd2);
        wait_idle_a("single_idle");

        // Burst of four: contiguous eight-cycle active window
        first = -1; last = -1; cnt_act = 0;
        for (int i = 0; i < 4; i++) begin
            push_a(ch3[i], 1'b1);
            chk("burst_level", 32'(ifa.level), 32'(lv5[i]));
            if (ifa.dmx_active) begin
                if (first < 0) first = i;
                last = i;
                cnt_act++;
            end
        end
        for (t = 4; t < 20; t++) begin
            @(negedge clk);
            if (ifa.dmx_active) begin
                if (first < 0) first = t;
                last = t;
                cnt_act++;
            end
        end
        chk("burst_active_cycles", 32'(cnt_act), 32'd8);
        chk("burst_span", 32'(last - first + 1), 32'd8);
        chk("burst_first", 32'(first), 32'd1);
        wait_idle_a("burst_idle");

        // Push on a pop edge at level 2, mixed data, order must hold
        for (int i = 0; i < 4; i++) begin
            push_a(ch5[i], d5[i]);
            chk("simul_level", 32'(ifa.level), 32'(lv5[i]));
        end
        wait_idle_a("simul_idle");

        // Full on the slow instance
        for (int i = 0; i < 6; i++) begin
            ifb.s_valid = 1'b1;
            ifb.s_chan  = 2'(i);
            ifb.s_data  = 1'b1;
            @(negedge clk);
            chk("full_level", 32'(ifb.level), 32'(lvb[i]));
        end
        ifb.s_valid = 1'b0;
        chk("full_ready_low", 32'(ifb.s_ready), 32'd0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("full_still_full", 32'(ifb.s_ready), 32'd0);
        @(negedge clk);
        chk("full_ready_back", 32'(ifb.s_ready), 32'd1);
        chk("full_level_after_pop", 32'(ifb.level), 32'd3);
        n = 0;
        while ((ifb.dmx_active || ifb.level != 3'd0) && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("full_drained", 32'(ifb.dmx_active), 32'd0);

        // Flush mid-hold with level 3 and a same-edge push
        for (int i = 0; i < 5; i++) begin
            push_a(chf[i], df[i]);
            chk("flush_fill_level", 32'(ifa.level), 32'(lvf[i]));
        end
        flush_a = 1'b1;
        ifa.s_valid = 1'b1; ifa.s_chan = 2'd3; ifa.s_data = 1'b1;
        @(negedge clk);
        flush_a = 1'b0;
        ifa.s_valid = 1'b0;
        chk("flush_level", 32'(ifa.level), 32'd0);
        chk("flush_active", 32'(ifa.dmx_active), 32'd0);
        chk("flush_data", 32'(ifa.dmx_data), 32'd0);
        chk("flush_sel_held", 32'(ifa.dmx_sel), 32'd2);
        for (int i = 0; i < 6; i++) @(negedge clk);
        chk("flush_no_reappear", 32'(ifa.dmx_active), 32'd0);
        chk("flush_queue", 32'(exp_q.size()), 32'd0);

        // Async reset in the middle of a hold
        push_a(2'd3, 1'b1);
        push_a(2'd1, 1'b1);
        chk("midrst_active", 32'(ifa.dmx_active), 32'd1);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_active_low", 32'(ifa.dmx_active), 32'd0);
        chk("midrst_data_low", 32'(ifa.dmx_data), 32'd0);
        chk("midrst_sel_low", 32'(ifa.dmx_sel), 32'd0);
        chk("midrst_level", 32'(ifa.level), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_ready", 32'(ifa.s_ready), 32'd1);
        mon_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("midrst_stays_idle", 32'(ifa.dmx_active), 32'd0);

        // Operation resumes after reset
        push_a(2'd1, 1'b1);
        wait_idle_a("post_rst_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
